// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    // Writeback source identifiers: src0 = execute/ALU, src1 = load unit.
    typedef enum logic {
        WB_SRC_EXE = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    // Arbitration mode: NORMAL favours src0, FORCED favours src1.
    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCED = 1'b1
    } arb_state_e;

    localparam logic [4:0]  REG_X0             = 5'd0;
    localparam logic [31:0] ZERO               = 32'd0;
    localparam int          DEF_DWIDTH         = 32;
    localparam int          DEF_STARVE_LIMIT   = 4;

    // A request only competes for the write port when it targets a real register.
    function automatic logic is_real_req(input logic valid, input logic [4:0] rd);
        return valid && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback-source handshakes, decode busy queries and the
// register-file write port driven by the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DWIDTH = 32
);
    logic              s0_valid_i;
    logic [4:0]        s0_rd_i;
    logic [DWIDTH-1:0] s0_data_i;
    logic              s0_ready_o;

    logic              s1_valid_i;
    logic [4:0]        s1_rd_i;
    logic [DWIDTH-1:0] s1_data_i;
    logic              s1_ready_o;

    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic              rs1_busy_o;
    logic              rs2_busy_o;

    logic              regwren_o;
    logic [4:0]        rd_o;
    logic [DWIDTH-1:0] datawb_o;

    // Arbiter side.
    modport slave (
        input  s0_valid_i, s0_rd_i, s0_data_i,
        output s0_ready_o,
        input  s1_valid_i, s1_rd_i, s1_data_i,
        output s1_ready_o,
        input  rs1_i, rs2_i,
        output rs1_busy_o, rs2_busy_o,
        output regwren_o, rd_o, datawb_o
    );

    // Pipeline/environment side.
    modport master (
        output s0_valid_i, s0_rd_i, s0_data_i,
        input  s0_ready_o,
        output s1_valid_i, s1_rd_i, s1_data_i,
        input  s1_ready_o,
        output rs1_i, rs2_i,
        input  rs1_busy_o, rs2_busy_o,
        input  regwren_o, rd_o, datawb_o
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_starve_counter.sv
// Counts consecutive cycles the load unit loses arbitration and switches the
// arbiter into FORCED mode once the wait reaches STARVE_LIMIT.
module wb_starve_counter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_s1_req,     // real (rd != x0) src1 request this cycle
    input  logic       i_s1_valid,   // raw src1 valid
    input  logic       i_s1_grant,   // src1 won the write port this cycle
    output arb_state_e o_state
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    arb_state_e    r_state;

    // Saturating loss count; an x0-only src1 request holds the count unchanged.
    always_comb begin
        w_count_next = r_count;
        if (i_s1_req && !i_s1_grant) begin
            w_count_next = (r_count == LIMIT) ? r_count : r_count + CW'(1);
        end else if (!i_s1_valid || i_s1_grant) begin
            w_count_next = '0;
        end
    end

    // Register the count and the mode derived from it so the mode is glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_state <= ARB_NORMAL;
        end else begin
            r_count <= w_count_next;
            r_state <= (w_count_next == LIMIT) ? ARB_FORCED : ARB_NORMAL;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the execute unit
// (src0, fixed priority) and the load unit (src1, starvation-guarded), registers
// the winning write, and reports pending writes to decode as busy flags.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    logic              w_s0_real;
    logic              w_s1_real;
    logic              w_s0_x0;
    logic              w_s1_x0;
    logic              w_g0;
    logic              w_g1;
    logic              w_grant;
    wb_src_e           w_winner;
    arb_state_e        w_state;

    logic              r_regwren;
    logic [4:0]        r_rd;
    logic [DWIDTH-1:0] r_datawb;

    assign w_s0_real = is_real_req(bus.s0_valid_i, bus.s0_rd_i);
    assign w_s1_real = is_real_req(bus.s1_valid_i, bus.s1_rd_i);
    assign w_s0_x0   = bus.s0_valid_i && (bus.s0_rd_i == REG_X0);
    assign w_s1_x0   = bus.s1_valid_i && (bus.s1_rd_i == REG_X0);

    wb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s1_req   (w_s1_real),
        .i_s1_valid (bus.s1_valid_i),
        .i_s1_grant (w_g1),
        .o_state    (w_state)
    );

    // Pick at most one real request; the mode decides who has priority.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (w_state == ARB_FORCED) begin
            w_g1 = w_s1_real;
            w_g0 = w_s0_real && !w_s1_real;
        end else begin
            w_g0 = w_s0_real;
            w_g1 = w_s1_real && !w_s0_real;
        end
    end

    assign w_grant  = w_g0 || w_g1;
    assign w_winner = w_g1 ? WB_SRC_LSU : WB_SRC_EXE;

    // x0 writes are discarded, so they are accepted immediately without arbitration.
    assign bus.s0_ready_o = w_g0 || w_s0_x0;
    assign bus.s1_ready_o = w_g1 || w_s1_x0;

    // Register the winning write; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regwren <= 1'b0;
            r_rd      <= REG_X0;
            r_datawb  <= '0;
        end else begin
            r_regwren <= w_grant;
            if (w_grant) begin
                r_rd     <= (w_winner == WB_SRC_LSU) ? bus.s1_rd_i   : bus.s0_rd_i;
                r_datawb <= (w_winner == WB_SRC_LSU) ? bus.s1_data_i : bus.s0_data_i;
            end
        end
    end

    assign bus.regwren_o = r_regwren;
    assign bus.rd_o      = r_rd;
    assign bus.datawb_o  = r_datawb;

    // A source register is busy while any write to it is requested or in flight.
    logic [4:0] w_rs   [2];
    logic       w_busy [2];

    assign w_rs[0] = bus.rs1_i;
    assign w_rs[1] = bus.rs2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_busy
            assign w_busy[gi] = (w_rs[gi] != REG_X0) && (
                                    (r_regwren      && (r_rd        == w_rs[gi])) ||
                                    (bus.s0_valid_i && (bus.s0_rd_i == w_rs[gi])) ||
                                    (bus.s1_valid_i && (bus.s1_rd_i == w_rs[gi])));
        end
    endgenerate

    assign bus.rs1_busy_o = w_busy[0];
    assign bus.rs2_busy_o = w_busy[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued when a
// grant is predicted and checked when the write appears on the port.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.DWIDTH(32)) bus ();

    regfile_wb_arbiter #(
        .DWIDTH       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t  sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   pend_vld = 1'b0;
    wr_t  pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of requests and check the combinational ready outputs.
    task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                         input logic er0, input logic er1, input string tag);
        bus.s0_valid_i = v0;
        bus.s0_rd_i    = rd0;
        bus.s0_data_i  = d0;
        bus.s1_valid_i = v1;
        bus.s1_rd_i    = rd1;
        bus.s1_data_i  = d1;
        #1;
        chk({tag, " s0_ready"}, 32'(bus.s0_ready_o), 32'(er0));
        chk({tag, " s1_ready"}, 32'(bus.s1_ready_o), 32'(er1));
        pend_vld = 1'b0;
        if (er0 && v0 && rd0 != 5'd0) begin
            pend_vld = 1'b1;
            pend = '{rd: rd0, data: d0};
        end else if (er1 && v1 && rd1 != 5'd0) begin
            pend_vld = 1'b1;
            pend = '{rd: rd1, data: d1};
        end
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, tag);
    endtask

    // Clock edge: the predicted write is owed only if reset was not sampled.
    task automatic tick();
        @(posedge clk);
        if (pend_vld && rst_n) sb_q.push_back(pend);
        pend_vld = 1'b0;
        #1;
    endtask

    // Write-port monitor: every registered write must match the oldest expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0) begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_en",   32'(bus.regwren_o), 32'd1);
                chk("wr_rd",   32'(bus.rd_o),      32'(e.rd));
                chk("wr_data", bus.datawb_o,       e.data);
                $display("write: rd=%0d data=0x%08h (expected rd=%0d data=0x%08h)",
                         bus.rd_o, bus.datawb_o, e.rd, e.data);
            end else begin
                chk("wr_idle", 32'(bus.regwren_o), 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.rs1_i = 5'd0;
        bus.rs2_i = 5'd0;
        // Reset held two cycles with both sources requesting.
        bus.s0_valid_i = 1'b1; bus.s0_rd_i = 5'd1; bus.s0_data_i = 32'h11;
        bus.s1_valid_i = 1'b1; bus.s1_rd_i = 5'd2; bus.s1_data_i = 32'h22;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("rst regwren", 32'(bus.regwren_o), 32'd0);
        chk("rst rd",      32'(bus.rd_o),      32'd0);
        chk("rst data",    bus.datawb_o,       32'd0);
        rst_n = 1'b1;
        idle("post_rst"); tick();

        // Single source, with busy tracking across request and in-flight cycles.
        bus.rs1_i = 5'd5;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "single");
        chk("single busy req", 32'(bus.rs1_busy_o), 32'd1);
        tick();
        idle("single+1");
        chk("single busy wb", 32'(bus.rs1_busy_o), 32'd1);
        tick();
        idle("single+2");
        chk("single busy done", 32'(bus.rs1_busy_o), 32'd0);
        chk("hold regwren", 32'(bus.regwren_o), 32'd0);
        chk("hold rd",      32'(bus.rd_o),      32'd5);
        chk("hold data",    bus.datawb_o,       32'hDEADBEEF);
        tick();

        // x0 from src0 alongside a real src1 write.
        bus.rs1_i = 5'd0;
        bus.rs2_i = 5'd9;
        drive(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, "x0mix");
        chk("x0 rs1 busy", 32'(bus.rs1_busy_o), 32'd0);
        chk("x0 rs2 busy", 32'(bus.rs2_busy_o), 32'd1);
        tick();
        idle("x0mix+1");
        chk("x0 rs1 busy wb", 32'(bus.rs1_busy_o), 32'd0);
        chk("x0 rs2 busy wb", 32'(bus.rs2_busy_o), 32'd1);
        tick();

        // Both sources x0: both accepted, no write.
        bus.rs2_i = 5'd0;
        drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 1'b1, 1'b1, "x0both");
        tick();
        idle("x0both+1"); tick();

        // Same destination from both sources: src0 first, src1 next.
        bus.rs1_i = 5'd4;
        drive(1'b1, 5'd4, 32'd1, 1'b1, 5'd4, 32'd2, 1'b1, 1'b0, "coll");
        chk("coll busy c1", 32'(bus.rs1_busy_o), 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd2, 1'b0, 1'b1, "coll+1");
        chk("coll busy c2", 32'(bus.rs1_busy_o), 32'd1);
        tick();
        idle("coll+2");
        chk("coll busy c3", 32'(bus.rs1_busy_o), 32'd1);
        tick();
        idle("coll+3");
        chk("coll busy c4", 32'(bus.rs1_busy_o), 32'd0);
        tick();
        bus.rs1_i = 5'd0;

        // Starvation: src0 wins four times, then src1 is forced through.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h30 + 32'(i), 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, "starve");
            tick();
        end
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1, "forced");
        tick();
        drive(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "resume");
        tick();
        idle("starve_end"); tick();

        // Reset sampled on a grant edge after src1 has lost three times.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd3, 32'h50 + 32'(i), 1'b1, 5'd7, 32'h78, 1'b1, 1'b0, "pre_rst");
            tick();
        end
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h60, 1'b1, 5'd7, 32'h78, 1'b1, 1'b0, "rst_grant");
        tick();
        rst_n = 1'b1;
        chk("midrst regwren", 32'(bus.regwren_o), 32'd0);
        // Counter must restart from zero: four more src0 wins before src1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h70 + 32'(i), 1'b1, 5'd7, 32'h79, 1'b1, 1'b0, "post_rst");
            tick();
        end
        drive(1'b1, 5'd3, 32'h74, 1'b1, 5'd7, 32'h79, 1'b0, 1'b1, "post_forced");
        tick();
        idle("flush0"); tick();
        idle("flush1"); tick();

        chk("sb empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
